// File: rtl/main_memory_controller_if.sv
// Memory-port bus between the cache controller (master) and the backing memory (slave).
// The request is level-held by the master; the response is a one-cycle pulse plus held read data.
interface main_memory_controller_if #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int CACHE_LINE_SIZE = 32
);
  logic                       reqValid_MEM;
  logic [ADDRESS_WIDTH-1:0]   reqAddress_MEM;
  logic [CACHE_LINE_SIZE-1:0] reqDataOut_MEM;
  logic                       reqWen_MEM;
  logic                       respValid_MEM;
  logic [CACHE_LINE_SIZE-1:0] respDataIn_MEM;
  logic                       memBusy;

  modport master (
    output reqValid_MEM, reqAddress_MEM, reqDataOut_MEM, reqWen_MEM,
    input  respValid_MEM, respDataIn_MEM, memBusy
  );

  modport slave (
    input  reqValid_MEM, reqAddress_MEM, reqDataOut_MEM, reqWen_MEM,
    output respValid_MEM, respDataIn_MEM, memBusy
  );
endinterface

// File: rtl/main_memory_controller.sv
// Backing memory for the cache controller: one outstanding request, fixed read/write latency,
// line-wide storage array, one-cycle response pulse with registered, held read data.
module main_memory_controller #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int CACHE_LINE_SIZE = 32,
  parameter int DEPTH           = 1024,
  parameter int READ_LATENCY    = 4,
  parameter int WRITE_LATENCY   = 4
) (
  input logic                     clk,
  input logic                     rst,
  main_memory_controller_if.slave bus
);
  localparam int OFF     = $clog2(CACHE_LINE_SIZE / 8);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND, RELEASE} state_t;

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic [IDX_W-1:0]           idxQ;
  logic                       wenQ;
  logic [CACHE_LINE_SIZE-1:0] dataQ;
  logic                       respValidQ;
  logic [CACHE_LINE_SIZE-1:0] respDataQ;
  logic                       busyQ;
  logic [CACHE_LINE_SIZE-1:0] storage [DEPTH];

  logic [IDX_W-1:0] reqIdx;
  logic             commit;
  logic             unusedAddrBits;

  // Offset bits and bits above the index are dropped, so addresses alias modulo DEPTH.
  assign reqIdx         = bus.reqAddress_MEM[OFF +: IDX_W];
  assign unusedAddrBits = &{1'b0, bus.reqAddress_MEM};
  assign commit         = (state == ACCESS) && (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idxQ       <= '0;
      wenQ       <= 1'b0;
      dataQ      <= '0;
      respValidQ <= 1'b0;
      respDataQ  <= '0;
      busyQ      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.reqValid_MEM) begin
            idxQ  <= reqIdx;
            wenQ  <= bus.reqWen_MEM;
            dataQ <= bus.reqDataOut_MEM;
            cnt   <= bus.reqWen_MEM ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
            busyQ <= 1'b1;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            respValidQ <= 1'b1;
            if (!wenQ) respDataQ <= storage[idxQ];
            state <= RESPOND;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESPOND: begin
          respValidQ <= 1'b0;
          state      <= RELEASE;
        end
        RELEASE: begin
          // Wait for the requester to drop valid so a held request is not serviced twice.
          if (!bus.reqValid_MEM) begin
            busyQ <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is not reset; reset forces IDLE so an uncommitted write never lands.
  always_ff @(posedge clk) begin
    if (commit && wenQ) storage[idxQ] <= dataQ;
  end

  assign bus.respValid_MEM  = respValidQ;
  assign bus.respDataIn_MEM = respDataQ;
  assign bus.memBusy        = busyQ;
endmodule

// File: doc/main_memory_controller.md
# main_memory_controller

Backing-memory endpoint for the cache controller's memory port. It accepts one level-held request at a time on the `*_MEM` bus and services it after a configurable latency. Reads and writes go to an internal line-wide storage array. Each request gets a one-cycle `respValid_MEM` pulse, and read data stays valid after the pulse ends, because the controller consumes it one cycle later.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 32, byte address width.
- `CACHE_LINE_SIZE`, 32, line/word width in bits; also the array word width.
- `DEPTH`, 1024, number of array words; power of two.
- `READ_LATENCY`, 4, cycles from acceptance to response for reads; ≥1.
- `WRITE_LATENCY`, 4, cycles from acceptance to response for writes; ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low (asserted at 0).
- `reqValid_MEM`  in  1  request valid; level, held by requester until after response.
- `reqAddress_MEM`  in  ADDRESS_WIDTH  byte address.
- `reqDataOut_MEM`  in  CACHE_LINE_SIZE  write data.
- `reqWen_MEM`  in  1  1 = write, 0 = read.
- `respValid_MEM`  out  1  one-cycle completion pulse.
- `respDataIn_MEM`  out  CACHE_LINE_SIZE  read data; registered, held.
- `memBusy`  out  1  high whenever state ≠ IDLE.

## Operation
- Index = `reqAddress_MEM[OFF +: $clog2(DEPTH)]`, where OFF = `$clog2(CACHE_LINE_SIZE/8)`.
  - Low OFF bits are ignored.
  - Bits above the index are ignored, so addresses alias modulo DEPTH words.
- FSM states: IDLE, ACCESS, RESPOND, RELEASE.
- IDLE:
  - If `reqValid_MEM`=1, accept the request: latch index, `reqWen_MEM`, `reqDataOut_MEM`.
  - Load the counter with (wen ? WRITE_LATENCY : READ_LATENCY) − 1.
  - Go to ACCESS.
- ACCESS:
  - If counter = 0: go to RESPOND. On that edge, a write commits to the array; a read loads `respDataIn_MEM` from the array.
  - Otherwise decrement the counter.
  - Input changes during ACCESS are ignored; latched values are used.
- RESPOND:
  - `respValid_MEM`=1 for exactly this cycle.
  - Unconditionally go to RELEASE.
- RELEASE:
  - Stay until `reqValid_MEM`=0, then go to IDLE.
  - This guarantees the same held request is never serviced twice. A new request needs `reqValid_MEM` low for ≥1 cycle after the response.
- `respDataIn_MEM`:
  - Changes only on a read completion.
  - Holds its value through writes, idle, and RELEASE.
- Array contents:
  - Not touched by reset.
  - Undefined before first write; the bench initialises them via writes.
- Reset (rst=0, any time, asynchronous):
  - state→IDLE, counter→0, `respValid_MEM`=0, `respDataIn_MEM`=0, `memBusy`=0.
  - An in-flight write that has not reached its commit edge is discarded; the array keeps its old value.

## Timing
- Acceptance cycle A is the IDLE cycle with `reqValid_MEM`=1.
- For latency L, `respValid_MEM` is high in cycle A+L+1 only, where cycle A+1 is the first ACCESS cycle.
  - Example, L=4: accepted in cycle 0, pulse in cycle 5.
- Write data is visible to a read accepted any time after the write's RESPOND cycle.
- `respDataIn_MEM` is valid in the pulse cycle and remains stable afterwards.
- Interoperation with the cache controller:
  - The controller drops `reqValid_MEM` the cycle after the pulse.
  - RELEASE therefore lasts 1 cycle and IDLE is reached 2 cycles after the pulse.
- `memBusy` rises the cycle after acceptance and falls on entry to IDLE.
- No pipelining: one outstanding request; throughput ≤ 1 request per L+3 cycles.

## Test plan
Bench parameters: READ_LATENCY=4, WRITE_LATENCY=2, DEPTH=1024, CACHE_LINE_SIZE=32.
- Write: addr 0x0000_0010, data 0xDEADBEEF, wen=1, accepted cycle 0 → single `respValid_MEM` pulse in cycle 3 only; `respDataIn_MEM` unchanged.
- Read back: addr 0x0000_0010, wen=0, accepted cycle 0 → pulse in cycle 5; `respDataIn_MEM`=0xDEADBEEF in cycle 5 and still 0xDEADBEEF in cycles 6–7 after pulse drops.
- Aliasing: write 0x12345678 to addr 0x0000_1010, then read addr 0x0000_0010 → returns 0x12345678 (both map to index 4).
- Held request:
  - Keep `reqValid_MEM` high 10 cycles after a read pulse → no second pulse, `memBusy` stays 1.
  - Drop `reqValid_MEM` for 1 cycle, then raise it → a new response follows after the usual latency.
- Mid-access input change: read 0x10 accepted, then change the address to 0x20 and data/wen during ACCESS → response still returns index-4 data.
- Reset mid-write:
  - Setup: index 8 holds 0x00000000.
  - Stimulus: accept a write of 0xAAAA5555 to 0x20, pull `rst` low in cycle 1.
  - Required: `respValid_MEM`/`memBusy` drop immediately, `respDataIn_MEM`=0, and a read of 0x20 after release returns 0x00000000.
